// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - arbitrates read and write-back requests onto one data memory port
// and drops read returns that a pipeline flush has made stale.
module dmem_port_arbiter #(
    parameter int DDATAW = 64,
    parameter int DSIZEW = 4,
    parameter int DADDRW = 32,
    parameter int MAXRD  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DADDRW-1:0] r_address,
    output logic              r_dp_valid,
    input  logic              r_dp_ready,
    output logic [DDATAW-1:0] r_dp_read_data,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DADDRW-1:0] w_address,
    input  logic [DDATAW-1:0] w_wr_data,
    input  logic [DSIZEW-1:0] w_wr_size,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DADDRW-1:0] m_address,
    output logic              m_wr_en,
    output logic [DDATAW-1:0] m_wr_data,
    output logic [DSIZEW-1:0] m_wr_size,
    input  logic              m_dp_valid,
    output logic              m_dp_ready,
    input  logic [DDATAW-1:0] m_dp_read_data
);
    localparam int CNTW = $clog2(MAXRD) + 1;
    localparam logic [CNTW-1:0] RD_LIMIT = CNTW'(MAXRD);

    typedef enum logic [1:0] {IDLE, LOCK_R, LOCK_W} state_t;

    state_t            state, state_nxt;
    logic              last_w;
    logic [CNTW-1:0]   rd_cnt, drop_cnt;
    logic [DADDRW-1:0] hold_address;
    logic [DDATAW-1:0] hold_wr_data;
    logic [DSIZEW-1:0] hold_wr_size;
    logic              rd_elig, grant_r, grant_w, rd_acc, ret_hs, dropping;

    always_comb begin
        state_nxt = state;
        grant_r   = 1'b0;
        grant_w   = 1'b0;
        rd_elig   = r_valid && (rd_cnt < RD_LIMIT) && !flush;
        case (state)
            IDLE: begin
                if (rd_elig && w_valid) begin
                    grant_w = !last_w;
                    grant_r = last_w;
                end else begin
                    grant_r = rd_elig;
                    grant_w = w_valid;
                end
                if (!m_ready && grant_r) state_nxt = LOCK_R;
                else if (!m_ready && grant_w) state_nxt = LOCK_W;
            end
            LOCK_R: begin
                grant_r = 1'b1;
                if (m_ready) state_nxt = IDLE;
            end
            LOCK_W: begin
                grant_w = 1'b1;
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Requests are masked while reset is held so the memory never sees a stray grant.
        if (!reset) begin
            grant_r = 1'b0;
            grant_w = 1'b0;
        end
    end

    always_comb begin
        m_valid   = grant_r || grant_w;
        m_wr_en   = grant_w;
        m_address = '0;
        m_wr_data = '0;
        m_wr_size = '0;
        if (state != IDLE) begin
            if (m_valid) begin
                m_address = hold_address;
                m_wr_data = hold_wr_data;
                m_wr_size = hold_wr_size;
            end
        end else if (grant_w) begin
            m_address = w_address;
            m_wr_data = w_wr_data;
            m_wr_size = w_wr_size;
        end else if (grant_r) begin
            m_address = r_address;
        end
    end

    assign r_ready        = grant_r && m_ready;
    assign w_ready        = grant_w && m_ready;
    assign rd_acc         = r_ready;
    assign dropping       = (drop_cnt != '0);
    assign r_dp_valid     = reset && m_dp_valid && !dropping;
    assign m_dp_ready     = reset && (dropping || r_dp_ready);
    assign r_dp_read_data = m_dp_read_data;
    assign ret_hs         = m_dp_valid && m_dp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_w       <= 1'b0;
            rd_cnt       <= '0;
            drop_cnt     <= '0;
            hold_address <= '0;
            hold_wr_data <= '0;
            hold_wr_size <= '0;
        end else begin
            state <= state_nxt;
            if (r_ready || w_ready) last_w <= w_ready;
            if (rd_acc && !ret_hs) rd_cnt <= rd_cnt + 1'b1;
            else if (!rd_acc && ret_hs) rd_cnt <= rd_cnt - 1'b1;
            // Everything still in flight after this edge belongs to the flushed program path.
            if (flush) drop_cnt <= rd_cnt - CNTW'(ret_hs) + CNTW'(rd_acc);
            else if (dropping && m_dp_valid) drop_cnt <= drop_cnt - 1'b1;
            if (state == IDLE && m_valid && !m_ready) begin
                hold_address <= m_address;
                hold_wr_data <= m_wr_data;
                hold_wr_size <= m_wr_size;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter with a transaction-level model.
module tb_dmem_port_arbiter;
    localparam int DW = 64, SW = 4, AW = 32, MAXRD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush, r_valid, r_ready, r_dp_valid, r_dp_ready;
    logic [AW-1:0] r_address, w_address, m_address;
    logic [DW-1:0] r_dp_read_data, w_wr_data, m_wr_data, m_dp_read_data;
    logic [SW-1:0] w_wr_size, m_wr_size;
    logic          w_valid, w_ready, m_valid, m_ready, m_wr_en, m_dp_valid, m_dp_ready;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DDATAW(DW), .DSIZEW(SW), .DADDRW(AW), .MAXRD(MAXRD)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .r_valid(r_valid), .r_ready(r_ready), .r_address(r_address),
        .r_dp_valid(r_dp_valid), .r_dp_ready(r_dp_ready), .r_dp_read_data(r_dp_read_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_address(w_address),
        .w_wr_data(w_wr_data), .w_wr_size(w_wr_size),
        .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address), .m_wr_en(m_wr_en),
        .m_wr_data(m_wr_data), .m_wr_size(m_wr_size),
        .m_dp_valid(m_dp_valid), .m_dp_ready(m_dp_ready), .m_dp_read_data(m_dp_read_data)
    );

    typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] size;} mreq_t;
    typedef struct {logic mready; logic fwd;} ret_t;

    mreq_t         req_q[$];
    ret_t          ev_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] mem_q[$];
    logic          got_wr[$];
    mreq_t         mon_e;
    ret_t          mon_v;
    int            total = 0, bad = 0;
    // Model: who holds the port (0 none, 1 read, 2 write), who was served last, reads in flight.
    int            lock_who = 0, outstanding = 0, drop = 0, ret_pct = 0;
    bit            m_last_w = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event, want none", name);
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {~a, a} ^ 64'h0123_4567_89ab_cdef;
    endfunction

    task automatic new_r();
        r_address = $urandom;
    endtask

    task automatic new_w();
        w_address = $urandom;
        w_wr_data = {$urandom, $urandom};
        w_wr_size = 4'($urandom_range(15));
    endtask

    task automatic drive_ret();
        if (mem_q.size() > 0 && int'($urandom_range(99)) < ret_pct) begin
            m_dp_valid     = 1'b1;
            m_dp_read_data = mem_q[0];
        end else begin
            m_dp_valid     = 1'b0;
            m_dp_read_data = '0;
        end
    endtask

    task automatic step(output bit acc_r, output bit acc_w);
        int    who;
        bit    r_ok, acc, ret, dropping;
        mreq_t e;
        ret_t  rv;
        who = lock_who;
        if (who == 0) begin
            r_ok = r_valid && outstanding < MAXRD && !flush;
            if (r_ok && w_valid) who = m_last_w ? 1 : 2;
            else if (r_ok) who = 1;
            else if (w_valid) who = 2;
        end
        acc   = (who != 0) && m_ready;
        acc_r = acc && who == 1;
        acc_w = acc && who == 2;
        if (acc_w) begin
            e.wr = 1'b1; e.addr = w_address; e.data = w_wr_data; e.size = w_wr_size;
            req_q.push_back(e);
        end
        if (acc_r) begin
            e.wr = 1'b0; e.addr = r_address; e.data = '0; e.size = '0;
            req_q.push_back(e);
        end
        dropping = drop > 0;
        ret = m_dp_valid && (dropping || r_dp_ready);
        if (m_dp_valid) begin
            rv.mready = ret;
            rv.fwd    = !dropping;
            ev_q.push_back(rv);
            if (ret && !dropping) rd_q.push_back(mem_q[0]);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            m_last_w = acc_w;
            lock_who = 0;
        end else if (who != 0) begin
            lock_who = who;
        end
        if (ret) begin
            outstanding--;
            void'(mem_q.pop_front());
        end
        if (acc_r) begin
            outstanding++;
            mem_q.push_back(mem_data(r_address));
        end
        if (flush) drop = outstanding;
        else if (dropping && m_dp_valid) drop--;
        drive_ret();
    endtask

    task automatic drain();
        bit ar, aw;
        r_valid = 1'b0; w_valid = 1'b0; flush = 1'b0;
        m_ready = 1'b1; r_dp_ready = 1'b1; ret_pct = 100;
        drive_ret();
        for (int i = 0; i < 60 && (outstanding > 0 || lock_who != 0); i++) step(ar, aw);
        chk("drain_outstanding", 64'(outstanding), 0);
        #1 chk("drain_rd_cnt", 64'(dut.rd_cnt), 0);
        ret_pct = 0;
        drive_ret();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (m_valid && m_ready) begin
                if (req_q.size() == 0) fail_now("req_unexpected");
                else begin
                    mon_e = req_q.pop_front();
                    chk("req_wr_en", 64'(m_wr_en), 64'(mon_e.wr));
                    chk("req_addr", 64'(m_address), 64'(mon_e.addr));
                    chk("req_data", m_wr_data, mon_e.data);
                    chk("req_size", 64'(m_wr_size), 64'(mon_e.size));
                    chk("req_readys", 64'({r_ready, w_ready}), mon_e.wr ? 64'd1 : 64'd2);
                    got_wr.push_back(m_wr_en);
                end
            end
            if (m_dp_valid) begin
                if (ev_q.size() == 0) fail_now("ret_unexpected");
                else begin
                    mon_v = ev_q.pop_front();
                    chk("m_dp_ready", 64'(m_dp_ready), 64'(mon_v.mready));
                    chk("r_dp_valid", 64'(r_dp_valid), 64'(mon_v.fwd));
                end
            end
            if (r_dp_valid && r_dp_ready) begin
                if (rd_q.size() == 0) fail_now("rdata_unexpected");
                else chk("r_dp_read_data", r_dp_read_data, rd_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ar, aw;
        logic exp_seq [4];
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        flush = 0; r_dp_ready = 1; m_ready = 1; w_wr_size = 0; w_wr_data = 0;
        r_valid = 1; w_valid = 1; r_address = 32'h80; w_address = 32'h40;
        m_dp_valid = 1; m_dp_read_data = 64'hAA;
        reset = 1;
        #1 reset = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_r_ready", 64'(r_ready), 0);
        chk("rst_w_ready", 64'(w_ready), 0);
        chk("rst_m_address", 64'(m_address), 0);
        chk("rst_m_wr_en", 64'(m_wr_en), 0);
        chk("rst_m_wr_data", m_wr_data, 0);
        chk("rst_r_dp_valid", 64'(r_dp_valid), 0);
        m_dp_valid = 0; m_dp_read_data = 0;
        @(posedge clk);
        #1 reset = 1;

        // Round-robin from reset: write first, then alternate.
        got_wr.delete();
        new_r(); new_w();
        for (int i = 0; i < 4; i++) begin
            step(ar, aw);
            if (ar) new_r();
            if (aw) new_w();
        end
        chk("rr_count", 64'(got_wr.size()), 4);
        for (int i = 0; i < 4 && i < got_wr.size(); i++) chk("rr_seq", 64'(got_wr[i]), 64'(exp_seq[i]));
        drain();

        // Outstanding-read limit: fifth read waits for a return.
        r_valid = 1; new_r();
        for (int i = 0; i < 4; i++) begin
            step(ar, aw);
            if (ar) new_r();
        end
        for (int i = 0; i < 2; i++) begin
            #1 chk("full_m_valid", 64'(m_valid), 0);
            chk("full_r_ready", 64'(r_ready), 0);
            step(ar, aw);
        end
        ret_pct = 100; drive_ret();
        #1 chk("full_ret_m_valid", 64'(m_valid), 0);
        step(ar, aw);
        ret_pct = 0; drive_ret();
        #1 chk("after_ret_m_valid", 64'(m_valid), 1);
        chk("after_ret_r_ready", 64'(r_ready), 1);
        step(ar, aw);
        drain();

        // Flush with two reads in flight: both returns are swallowed.
        r_valid = 1; new_r();
        for (int i = 0; i < 2; i++) begin
            step(ar, aw);
            if (ar) new_r();
        end
        r_valid = 0; flush = 1;
        step(ar, aw);
        flush = 0; r_dp_ready = 0; ret_pct = 100; drive_ret();
        for (int i = 0; i < 2; i++) begin
            #1 chk("drop_r_dp_valid", 64'(r_dp_valid), 0);
            chk("drop_m_dp_ready", 64'(m_dp_ready), 1);
            step(ar, aw);
        end
        #1 chk("drop_rd_cnt", 64'(dut.rd_cnt), 0);
        chk("drop_drop_cnt", 64'(dut.drop_cnt), 0);
        drain();

        // Stalled read holds the port while a write waits.
        r_address = 32'h100; r_valid = 1; w_valid = 0; m_ready = 0;
        #1 chk("lock_addr0", 64'(m_address), 64'h100);
        step(ar, aw);
        w_valid = 1; new_w();
        for (int i = 0; i < 2; i++) begin
            #1 chk("lock_addr", 64'(m_address), 64'h100);
            chk("lock_w_ready", 64'(w_ready), 0);
            step(ar, aw);
        end
        m_ready = 1;
        #1 chk("lock_acc_addr", 64'(m_address), 64'h100);
        chk("lock_acc_r_ready", 64'(r_ready), 1);
        chk("lock_acc_w_ready", 64'(w_ready), 0);
        step(ar, aw);
        r_valid = 0;
        step(ar, aw);
        drain();

        // Reset during a stalled write; afterwards write wins again.
        w_valid = 1; new_w(); m_ready = 0;
        step(ar, aw);
        reset = 0;
        #1 chk("rst_lock_m_valid", 64'(m_valid), 0);
        chk("rst_lock_w_ready", 64'(w_ready), 0);
        lock_who = 0; m_last_w = 0; outstanding = 0; drop = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1; m_ready = 1; r_valid = 1; new_r();
        #1 chk("post_rst_wr_en", 64'(m_wr_en), 1);
        chk("post_rst_w_ready", 64'(w_ready), 1);
        step(ar, aw);
        if (ar) r_valid = 0;
        if (aw) w_valid = 0;

        ret_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (!r_valid && $urandom_range(99) < 50) begin r_valid = 1; new_r(); end
            if (!w_valid && $urandom_range(99) < 40) begin w_valid = 1; new_w(); end
            flush      = $urandom_range(99) < 5;
            m_ready    = $urandom_range(99) < 70;
            r_dp_ready = $urandom_range(99) < 70;
            step(ar, aw);
            if (ar) r_valid = 0;
            if (aw) w_valid = 0;
        end
        drain();
        chk("req_q_left", 64'(req_q.size()), 0);
        chk("ev_q_left", 64'(ev_q.size()), 0);
        chk("rd_q_left", 64'(rd_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
